// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared state, opcode, ALU and mux-select encodings for the MC-CPU control path.
package mc_cpu_pkg;

    localparam int STATE_W = 3;
    localparam int OPC_W   = 6;

    typedef enum logic [STATE_W-1:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    localparam logic [OPC_W-1:0] OP_ADD   = 6'b000000;
    localparam logic [OPC_W-1:0] OP_SUB   = 6'b000001;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b000010;
    localparam logic [OPC_W-1:0] OP_OR    = 6'b010000;
    localparam logic [OPC_W-1:0] OP_AND   = 6'b010001;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b010010;
    localparam logic [OPC_W-1:0] OP_SLL   = 6'b011000;
    localparam logic [OPC_W-1:0] OP_SLT   = 6'b100110;
    localparam logic [OPC_W-1:0] OP_SLTIU = 6'b100111;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b110000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b110001;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b110100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b111000;
    localparam logic [OPC_W-1:0] OP_JR    = 6'b111001;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'b111010;
    localparam logic [OPC_W-1:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;

    localparam logic [1:0] REG_RA = 2'b00;
    localparam logic [1:0] REG_RT = 2'b01;
    localparam logic [1:0] REG_RD = 2'b10;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JR  = 2'b10;
    localparam logic [1:0] PC_J   = 2'b11;

    // Instruction class drives the FSM path; undefined opcodes fall into CL_NOP.
    typedef enum logic [3:0] {
        CL_NOP, CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JR, CL_JAL, CL_HALT
    } op_class_e;

    typedef struct packed {
        logic       alu_src_b;
        logic       sa_ext;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic       alum2reg;
        logic       wr_reg_data;
        logic [1:0] reg_out;
    } sel_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode: combinational opcode to instruction class and datapath select signals.
module mc_opcode_decode
    import mc_cpu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output sel_t             sel_o,
    output op_class_e        cls_o
);

    always_comb begin
        sel_o = '{alu_src_b: 1'b0, sa_ext: 1'b0, alu_op: ALU_ADD, ext_sel: 1'b1,
                  alum2reg: 1'b0, wr_reg_data: 1'b1, reg_out: REG_RA};
        cls_o = CL_NOP;
        case (opcode_i)
            OP_ADD: begin
                cls_o = CL_ALU;
                sel_o.reg_out = REG_RD;
            end
            OP_SUB: begin
                cls_o = CL_ALU;
                sel_o.reg_out = REG_RD;
                sel_o.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                cls_o = CL_ALU;
                sel_o.alu_src_b = 1'b1;
                sel_o.reg_out = REG_RT;
            end
            OP_OR: begin
                cls_o = CL_ALU;
                sel_o.reg_out = REG_RD;
                sel_o.alu_op = ALU_OR;
            end
            OP_AND: begin
                cls_o = CL_ALU;
                sel_o.reg_out = REG_RD;
                sel_o.alu_op = ALU_AND;
            end
            OP_ORI: begin
                cls_o = CL_ALU;
                sel_o.alu_src_b = 1'b1;
                sel_o.reg_out = REG_RT;
                sel_o.alu_op = ALU_OR;
                sel_o.ext_sel = 1'b0;
            end
            OP_SLL: begin
                cls_o = CL_ALU;
                sel_o.reg_out = REG_RD;
                sel_o.alu_op = ALU_SLL;
                sel_o.sa_ext = 1'b1;
            end
            OP_SLT: begin
                cls_o = CL_ALU;
                sel_o.reg_out = REG_RD;
                sel_o.alu_op = ALU_SLT;
            end
            OP_SLTIU: begin
                cls_o = CL_ALU;
                sel_o.alu_src_b = 1'b1;
                sel_o.reg_out = REG_RT;
                sel_o.alu_op = ALU_SLTU;
            end
            OP_SW: begin
                cls_o = CL_SW;
                sel_o.alu_src_b = 1'b1;
            end
            OP_LW: begin
                cls_o = CL_LW;
                sel_o.alu_src_b = 1'b1;
                sel_o.reg_out = REG_RT;
                sel_o.alum2reg = 1'b1;
            end
            OP_BEQ: begin
                cls_o = CL_BEQ;
                sel_o.alu_op = ALU_SUB;
            end
            OP_J:    cls_o = CL_J;
            OP_JR:   cls_o = CL_JR;
            OP_JAL: begin
                cls_o = CL_JAL;
                sel_o.wr_reg_data = 1'b0;
            end
            OP_HALT: cls_o = CL_HALT;
            default: cls_o = CL_NOP;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle instruction-phase FSM and datapath strobe/select generation.
module mc_control_unit
    import mc_cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             RegWre,
    output logic             DataMemRW,
    output logic             ALUSrcB,
    output logic             SAExt,
    output logic [2:0]       ALUOp,
    output logic             ExtSel,
    output logic             ALUM2Reg,
    output logic             WrRegData,
    output logic [1:0]       RegOut,
    output logic [1:0]       PCSrc,
    output logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] next_state
);

    state_e    state_q, state_d;
    sel_t      sel;
    op_class_e cls;
    logic      in_if;

    mc_opcode_decode u_dec (
        .opcode_i (opcode),
        .sel_o    (sel),
        .cls_o    (cls)
    );

    always_ff @(posedge clk) begin
        state_q <= reset ? S_IF : state_d;
    end

    always_comb begin
        state_d   = state_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        DataMemRW = 1'b0;
        PCSrc     = PC_SEQ;
        case (state_q)
            S_IF: begin
                state_d  = S_ID;
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
            end
            S_ID: begin
                case (cls)
                    CL_ALU:       state_d = S_EXE_AL;
                    CL_LW, CL_SW: state_d = S_EXE_LS;
                    CL_BEQ:       state_d = S_EXE_BR;
                    CL_HALT:      state_d = S_ID;
                    default: begin
                        // Jumps and undefined opcodes retire in ID.
                        state_d = S_IF;
                        PCWre   = 1'b1;
                        RegWre  = cls == CL_JAL;
                        PCSrc   = (cls == CL_J || cls == CL_JAL) ? PC_J :
                                  cls == CL_JR ? PC_JR : PC_SEQ;
                    end
                endcase
            end
            S_EXE_LS: state_d = S_MEM;
            S_MEM: begin
                state_d   = cls == CL_SW ? S_IF : S_WB_LD;
                PCWre     = cls == CL_SW;
                DataMemRW = cls == CL_SW;
            end
            S_WB_LD: begin
                state_d = S_IF;
                PCWre   = 1'b1;
                RegWre  = 1'b1;
            end
            S_EXE_BR: begin
                state_d = S_IF;
                PCWre   = 1'b1;
                PCSrc   = zero ? PC_BR : PC_SEQ;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL: begin
                state_d = S_IF;
                PCWre   = 1'b1;
                RegWre  = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    assign in_if      = state_q == S_IF;
    assign ALUSrcB    = !in_if && sel.alu_src_b;
    assign SAExt      = !in_if && sel.sa_ext;
    assign ALUOp      = in_if ? ALU_ADD : sel.alu_op;
    assign ExtSel     = !in_if && sel.ext_sel;
    assign ALUM2Reg   = !in_if && sel.alum2reg;
    assign WrRegData  = !in_if && sel.wr_reg_data;
    assign RegOut     = in_if ? REG_RA : sel.reg_out;
    assign state      = state_q;
    assign next_state = state_d;

endmodule
